// File: rtl/pulse_pwm.sv
// pulse_pwm: breathing PWM stage. Consumes an external free-running period
// counter and its overflow strobe, ramps the duty up and down in a triangle,
// and swaps in a new duty only at period boundaries so the output never glitches.
//
// There is no valid/ready handshake here. 'overflow' is a one-cycle strobe
// with no back-pressure. 'step' and 'rate' are only looked at in
// overflow cycles.
module pulse_pwm #(
  parameter int counter_width = 16,
  parameter int rate_width    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [counter_width-1:0] counter,
  input  logic                     overflow,
  input  logic                     enable,
  input  logic [counter_width-1:0] step,
  input  logic [rate_width-1:0]    rate,
  output logic                     pwm_out,
  output logic [counter_width-1:0] duty,
  output logic                     peak,
  output logic                     trough
);

  localparam logic [counter_width-1:0] max_val = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [counter_width-1:0] ramp;
  logic [counter_width-1:0] ramp_next;
  logic [rate_width-1:0]    presc;
  logic [rate_width-1:0]    presc_next;
  logic                     peak_next;
  logic                     trough_next;
  logic [counter_width:0]   sum;
  logic [counter_width-1:0] duty_eff;

  // The sum is one bit wider than the ramp so that saturating at MAX never
  // sees a wrapped value. On a boundary the compare uses the duty that is
  // being loaded in that same cycle.
  always_comb begin
    sum      = {1'b0, ramp} + {1'b0, step};
    duty_eff = overflow ? ramp : duty;
  end

  // Next-state logic for the ramp FSM and the prescaler. A low enable takes
  // priority over any ramp update in the same cycle. The prescaler compare
  // uses >= so that lowering 'rate' mid-run cannot make the count wrap.
  always_comb begin
    state_next  = state;
    ramp_next   = ramp;
    presc_next  = presc;
    peak_next   = 1'b0;
    trough_next = 1'b0;
    case (state)
      IDLE: begin
        ramp_next  = '0;
        presc_next = '0;
        if (enable) state_next = UP;
      end
      UP, DOWN: begin
        if (!enable) begin
          state_next = IDLE;
          ramp_next  = '0;
          presc_next = '0;
        end else if (overflow) begin
          if (presc >= rate) begin
            presc_next = '0;
            if (state == UP) begin
              if (sum >= {1'b0, max_val}) begin
                ramp_next  = max_val;
                state_next = DOWN;
                peak_next  = 1'b1;
              end else begin
                ramp_next = sum[counter_width-1:0];
              end
            end else begin
              if (ramp <= step) begin
                ramp_next   = '0;
                state_next  = UP;
                trough_next = 1'b1;
              end else begin
                ramp_next = ramp - step;
              end
            end
          end else begin
            presc_next = presc + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        ramp_next  = '0;
        presc_next = '0;
      end
    endcase
  end

  // State, ramp and prescaler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ramp   <= '0;
      presc  <= '0;
      peak   <= 1'b0;
      trough <= 1'b0;
    end else begin
      state  <= state_next;
      ramp   <= ramp_next;
      presc  <= presc_next;
      peak   <= peak_next;
      trough <= trough_next;
    end
  end

  // The active duty loads the pre-update ramp at each boundary. The PWM
  // compare is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (overflow) duty <= ramp;
      pwm_out <= (counter < duty_eff);
    end
  end

endmodule

// File: tb/tb_pulse_pwm.sv
// tb_pulse_pwm: per-period vector table for the breathing ramp, plus
// hand-written sequences for mid-period reset and lowering the rate.
// The whole output vector {pwm_out, peak, trough, duty} is checked on
// every cycle through an expected queue.
module tb_pulse_pwm;

  localparam int CW = 4;
  localparam int RW = 8;
  localparam int W  = CW + 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] counter;
  logic          overflow;
  logic          enable;
  logic [CW-1:0] step;
  logic [RW-1:0] rate;
  logic          pwm_out;
  logic [CW-1:0] duty;
  logic          peak;
  logic          trough;

  always #5 clk = ~clk;

  pulse_pwm #(.counter_width(CW), .rate_width(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .counter  (counter),
    .overflow (overflow),
    .enable   (enable),
    .step     (step),
    .rate     (rate),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .peak     (peak),
    .trough   (trough)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  string        phase  = "init";

  function automatic logic [W-1:0] pack_exp(input logic p, input logic pk,
                                             input logic tr, input logic [CW-1:0] d);
    return {p, pk, tr, d};
  endfunction

  task automatic check_pop(input int c);
    logic [W-1:0] e;
    logic [W-1:0] act;
    act = {pwm_out, peak, trough, duty};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s c=%0d: scoreboard empty, got %b", phase, c, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s c=%0d: {pwm,peak,trough,duty} got %b required %b",
                 phase, c, act, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one counter value, push what the DUT must show after the edge,
  // then sample 1 ns after that edge.
  task automatic drive_cycle(input logic [CW-1:0] c, input logic [W-1:0] e);
    counter  = c;
    overflow = (c == '0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(int'(c));
  endtask

  // One full period whose duty must be d, with peak/trough expected in the
  // cycle after the boundary. The inputs change in the middle of the period.
  task automatic run_period(input logic [CW-1:0] d, input logic pk, input logic tr,
                            input logic en_mid, input logic [CW-1:0] step_mid,
                            input logic [RW-1:0] rate_mid);
    for (int c = 0; c < 16; c++) begin
      logic [CW-1:0] cv;
      cv = CW'(c);
      if (c == 8) begin
        enable = en_mid;
        step   = step_mid;
        rate   = rate_mid;
      end
      drive_cycle(cv, pack_exp(cv < d, (c == 0) && pk, (c == 0) && tr, d));
    end
  endtask

  task automatic do_reset(input logic [CW-1:0] s, input logic [RW-1:0] r);
    rst    = 1'b1;
    enable = 1'b0;
    step   = s;
    rate   = r;
    for (int i = 0; i < 3; i++) drive_cycle(CW'(15), pack_exp(1'b0, 1'b0, 1'b0, CW'(0)));
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic          en;
    logic [CW-1:0] step;
    logic [RW-1:0] rate;
    logic [CW-1:0] duty;
    logic          pk;
    logic          tr;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic en, input logic [CW-1:0] s,
                              input logic [RW-1:0] r, input logic [CW-1:0] d,
                              input logic pk, input logic tr);
    vec_t v;
    v.en = en; v.step = s; v.rate = r; v.duty = d; v.pk = pk; v.tr = tr;
    return v;
  endfunction

  initial begin
    rst = 1'b1; counter = CW'(15); overflow = 1'b0;
    enable = 1'b0; step = CW'(4); rate = '0;

    // Idle for 3 periods, then the full triangle at step 4, rate 0.
    tbl[0]  = mk(1'b0, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 4'd4,  8'd0, 4'd4,  1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 4'd4,  8'd0, 4'd8,  1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 4'd4,  8'd0, 4'd12, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 4'd4,  8'd0, 4'd15, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 4'd4,  8'd0, 4'd11, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 4'd4,  8'd0, 4'd7,  1'b0, 1'b0);
    tbl[11] = mk(1'b1, 4'd4,  8'd0, 4'd3,  1'b0, 1'b1);
    tbl[12] = mk(1'b1, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[13] = mk(1'b1, 4'd4,  8'd0, 4'd4,  1'b0, 1'b0);
    tbl[14] = mk(1'b1, 4'd4,  8'd0, 4'd8,  1'b0, 1'b0);
    // Enable dropped mid-period at duty 12: the period finishes at 12, then 0.
    tbl[15] = mk(1'b0, 4'd4,  8'd0, 4'd12, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    // Re-enable restarts from 0, then rate 2 holds each duty for 3 periods.
    tbl[17] = mk(1'b1, 4'd4,  8'd0, 4'd0,  1'b0, 1'b0);
    tbl[18] = mk(1'b1, 4'd4,  8'd2, 4'd0,  1'b0, 1'b0);
    tbl[19] = mk(1'b1, 4'd4,  8'd2, 4'd4,  1'b0, 1'b0);
    tbl[20] = mk(1'b1, 4'd4,  8'd2, 4'd4,  1'b0, 1'b0);
    tbl[21] = mk(1'b1, 4'd4,  8'd2, 4'd4,  1'b0, 1'b0);
    tbl[22] = mk(1'b1, 4'd4,  8'd2, 4'd8,  1'b0, 1'b0);
    tbl[23] = mk(1'b1, 4'd4,  8'd2, 4'd8,  1'b0, 1'b0);
    tbl[24] = mk(1'b1, 4'd4,  8'd2, 4'd8,  1'b0, 1'b0);
    // Disable, then step = MAX from ramp 0: peak at 15, trough back to 0.
    tbl[25] = mk(1'b0, 4'd15, 8'd0, 4'd12, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 4'd15, 8'd0, 4'd0,  1'b0, 1'b0);
    tbl[27] = mk(1'b1, 4'd15, 8'd0, 4'd0,  1'b1, 1'b0);
    tbl[28] = mk(1'b1, 4'd15, 8'd0, 4'd15, 1'b0, 1'b1);
    tbl[29] = mk(1'b1, 4'd15, 8'd0, 4'd0,  1'b1, 1'b0);

    phase = "reset";
    do_reset(CW'(4), RW'(0));

    for (int i = 0; i < 30; i++) begin
      phase = $sformatf("period%0d", i);
      run_period(tbl[i].duty, tbl[i].pk, tbl[i].tr, tbl[i].en, tbl[i].step, tbl[i].rate);
    end

    // Reset in the middle of a duty-15 period: everything clears on the
    // next edge, then the ramp restarts from 0 with enable still high.
    phase = "mid_reset";
    for (int c = 0; c < 5; c++)
      drive_cycle(CW'(c), pack_exp(1'b1, 1'b0, c == 0, CW'(15)));
    rst = 1'b1;
    drive_cycle(CW'(5), pack_exp(1'b0, 1'b0, 1'b0, CW'(0)));
    rst = 1'b0;
    for (int c = 6; c < 16; c++)
      drive_cycle(CW'(c), pack_exp(1'b0, 1'b0, 1'b0, CW'(0)));
    phase = "after_reset";
    run_period(CW'(0),  1'b1, 1'b0, 1'b1, CW'(15), RW'(0));
    run_period(CW'(15), 1'b0, 1'b1, 1'b1, CW'(15), RW'(0));

    // Lower the rate from 5 to 1 once the prescaler has reached 4: the update
    // happens at the very next boundary, not after a wrap.
    phase = "rate_reset";
    do_reset(CW'(1), RW'(5));
    phase = "rate_lower";
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(5));
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(5));
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(5));
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(5));
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(1));
    run_period(CW'(0), 1'b0, 1'b0, 1'b1, CW'(1), RW'(1));
    run_period(CW'(1), 1'b0, 1'b0, 1'b1, CW'(1), RW'(1));
    run_period(CW'(1), 1'b0, 1'b0, 1'b1, CW'(1), RW'(1));
    run_period(CW'(2), 1'b0, 1'b0, 1'b1, CW'(1), RW'(1));

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
